// File: rtl/cpu_regfile.sv
// -----------------------------------------------------------------------------
// cpu_regfile
// Register file and M-cycle sequencer for the SM83 CPU datapath.
//
// Holds NUM_REGS byte registers. They are addressed as single bytes or as
// high/low pairs: pair k = {reg 2k, reg 2k+1}. PC lives in pair PC_PAIR and
// the flags live in byte FLAG_REG.
//
// A T-cycle phase counter runs 0 .. T_PER_M-1. Every register update is
// gathered combinationally and committed on the clock edge that ends the
// M-cycle. Nothing changes on any other edge.
//
// Optional feature macro: CPU_REGFILE_STALL_EN
//   defined   : mem_ready_i = 0 on the final T-cycle holds the phase counter
//               and all state, and suppresses commit.
//   undefined : mem_ready_i is ignored and every final T-cycle commits.
//
// Ports
//   clk_i            clock
//   reset_i          synchronous active-high reset
//   mem_ready_i      memory ready, sampled on the final T-cycle
//   t_cycle_o        current T-cycle phase
//   commit_o         this clock edge ends the M-cycle and commits updates
//   rd1_idx_i/rd2_idx_i, rd1_data_o/rd2_data_o
//                    asynchronous byte reads (out-of-range index reads 0)
//   wr_en_i, wr_idx_i, wr_data_i
//                    byte write port
//   inc_op_i         0 none, 1 inc, 2 dec, 3 inc without writeback
//   inc_pair_i       pair feeding the incrementer
//   inc_in_o         selected pair value
//   inc_out_o        incrementer result
//   pc_load_i        load PC from inc_out_o at commit
//   pc_o             current PC
//   flag_wr_en_i, flag_data_i
//                    direct flags write
//   mcycle_count_o   number of committed M-cycles (wraps)
// -----------------------------------------------------------------------------
module cpu_regfile #(
    parameter int                  DATA_W    = 8,
    parameter int                  NUM_REGS  = 14,
    parameter int                  T_PER_M   = 4,
    parameter int                  PC_PAIR   = 6,
    parameter int                  FLAG_REG  = 6,
    parameter logic [DATA_W-1:0]   FLAG_MASK = 8'hF0,
    parameter logic [2*DATA_W-1:0] RESET_PC  = 16'h0000,
    localparam int                 IW        = $clog2(NUM_REGS),
    localparam int                 PW        = IW - 1,
    localparam int                 TW        = $clog2(T_PER_M)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                mem_ready_i,
    output logic [TW-1:0]       t_cycle_o,
    output logic                commit_o,
    input  logic [IW-1:0]       rd1_idx_i,
    input  logic [IW-1:0]       rd2_idx_i,
    output logic [DATA_W-1:0]   rd1_data_o,
    output logic [DATA_W-1:0]   rd2_data_o,
    input  logic                wr_en_i,
    input  logic [IW-1:0]       wr_idx_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [1:0]          inc_op_i,
    input  logic [PW-1:0]       inc_pair_i,
    output logic [2*DATA_W-1:0] inc_in_o,
    output logic [2*DATA_W-1:0] inc_out_o,
    input  logic                pc_load_i,
    output logic [2*DATA_W-1:0] pc_o,
    input  logic                flag_wr_en_i,
    input  logic [DATA_W-1:0]   flag_data_i,
    output logic [15:0]         mcycle_count_o
);

    localparam int            NUM_PAIRS = NUM_REGS / 2;
    localparam logic [TW-1:0] T_LAST    = TW'(T_PER_M - 1);

    // Clears every flags bit that lies outside FLAG_MASK.
    function automatic logic [DATA_W-1:0] mask_flags(input logic [DATA_W-1:0] val);
        return val & FLAG_MASK;
    endfunction

    // Byte of a pair value that lands in register idx (even = high byte).
    function automatic logic [DATA_W-1:0] pair_byte(input logic [2*DATA_W-1:0] val,
                                                    input int idx);
        return (idx % 2 == 0) ? val[2*DATA_W-1:DATA_W] : val[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [TW-1:0]       t_cycle_q;
    logic [TW-1:0]       t_cycle_d;
    logic [15:0]         mcycle_q;
    logic [15:0]         mcycle_d;
    logic                ready_s;
    logic                commit_s;
    logic                inc_wb_s;
    logic [2*DATA_W-1:0] inc_in_s;
    logic [2*DATA_W-1:0] inc_out_s;

`ifdef CPU_REGFILE_STALL_EN
    assign ready_s = mem_ready_i;
`else
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = mem_ready_i;
    assign ready_s            = 1'b1;
`endif

    // Reset overrides the final T-cycle, so an interrupted M-cycle never commits.
    assign commit_s = (t_cycle_q == T_LAST) && ready_s && !reset_i;
    assign inc_wb_s = (inc_op_i == 2'd1) || (inc_op_i == 2'd2);

    // Asynchronous read ports; an unmatched index falls through to zero.
    always_comb begin
        rd1_data_o = '0;
        rd2_data_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd1_idx_i == IW'(i)) begin
                rd1_data_o = regs_q[i];
            end else begin
                rd1_data_o = rd1_data_o;
            end
            if (rd2_idx_i == IW'(i)) begin
                rd2_data_o = regs_q[i];
            end else begin
                rd2_data_o = rd2_data_o;
            end
        end
    end

    // Pair selection feeding the incrementer; a nonexistent pair reads zero.
    always_comb begin
        inc_in_s = '0;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (inc_pair_i == PW'(p)) begin
                inc_in_s = {regs_q[2*p], regs_q[2*p+1]};
            end else begin
                inc_in_s = inc_in_s;
            end
        end
    end

    // 16-bit incrementer/decrementer, wrapping modulo the pair width.
    always_comb begin
        inc_out_s = inc_in_s;
        case (inc_op_i)
            2'd1, 2'd3: inc_out_s = inc_in_s + (2*DATA_W)'(1);
            2'd2:       inc_out_s = inc_in_s - (2*DATA_W)'(1);
            default:    inc_out_s = inc_in_s;
        endcase
    end

    // Next register state: highest-priority source first in the if chain.
    always_comb begin
        regs_d = regs_q;
        if (commit_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (pc_load_i && ((i / 2) == PC_PAIR)) begin
                    regs_d[i] = pair_byte(inc_out_s, i);
                end else if (inc_wb_s && (inc_pair_i == PW'(i / 2))) begin
                    regs_d[i] = pair_byte(inc_out_s, i);
                end else if (wr_en_i && (wr_idx_i == IW'(i))) begin
                    regs_d[i] = wr_data_i;
                end else if (flag_wr_en_i && (i == FLAG_REG)) begin
                    regs_d[i] = flag_data_i;
                end else begin
                    regs_d[i] = regs_q[i];
                end
            end
            // Applied after source selection so every path into F is masked.
            regs_d[FLAG_REG] = mask_flags(regs_d[FLAG_REG]);
        end else begin
            regs_d = regs_q;
        end
    end

    // Phase counter: wraps after the final T-cycle, holds there while stalled.
    always_comb begin
        t_cycle_d = t_cycle_q;
        if (t_cycle_q == T_LAST) begin
            if (ready_s) begin
                t_cycle_d = '0;
            end else begin
                t_cycle_d = t_cycle_q;
            end
        end else begin
            t_cycle_d = t_cycle_q + TW'(1);
        end
    end

    // Committed M-cycle counter.
    always_comb begin
        if (commit_s) begin
            mcycle_d = mcycle_q + 16'd1;
        end else begin
            mcycle_d = mcycle_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[2*PC_PAIR]   <= RESET_PC[2*DATA_W-1:DATA_W];
            regs_q[2*PC_PAIR+1] <= RESET_PC[DATA_W-1:0];
            t_cycle_q           <= '0;
            mcycle_q            <= 16'd0;
        end else begin
            regs_q    <= regs_d;
            t_cycle_q <= t_cycle_d;
            mcycle_q  <= mcycle_d;
        end
    end

    assign t_cycle_o      = t_cycle_q;
    assign commit_o       = commit_s;
    assign inc_in_o       = inc_in_s;
    assign inc_out_o      = inc_out_s;
    assign pc_o           = {regs_q[2*PC_PAIR], regs_q[2*PC_PAIR+1]};
    assign mcycle_count_o = mcycle_q;

endmodule

// File: tb/tb_cpu_regfile.sv
module tb_cpu_regfile;

    logic        clk;
    logic        reset;
    logic        mem_ready;
    logic [1:0]  t_cycle;
    logic        commit;
    logic [3:0]  rd1_idx, rd2_idx;
    logic [7:0]  rd1_data, rd2_data;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [7:0]  wr_data;
    logic [1:0]  inc_op;
    logic [2:0]  inc_pair;
    logic [15:0] inc_in, inc_out;
    logic        pc_load;
    logic [15:0] pc;
    logic        flag_wr_en;
    logic [7:0]  flag_data;
    logic [15:0] mcycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_regfile #(.RESET_PC(16'h0100)) dut (
        .clk_i(clk), .reset_i(reset), .mem_ready_i(mem_ready),
        .t_cycle_o(t_cycle), .commit_o(commit),
        .rd1_idx_i(rd1_idx), .rd2_idx_i(rd2_idx),
        .rd1_data_o(rd1_data), .rd2_data_o(rd2_data),
        .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
        .inc_op_i(inc_op), .inc_pair_i(inc_pair),
        .inc_in_o(inc_in), .inc_out_o(inc_out),
        .pc_load_i(pc_load), .pc_o(pc),
        .flag_wr_en_i(flag_wr_en), .flag_data_i(flag_data),
        .mcycle_count_o(mcycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [3:0]  wi;
        logic [7:0]  wd;
        logic        fe;
        logic [7:0]  fd;
        logic [1:0]  op;
        logic [2:0]  pair;
        logic        pl;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [15:0] exp_inc;
        logic [7:0]  exp_r1;
        logic [7:0]  exp_r2;
        logic [15:0] exp_pc;
    } vec_t;

    typedef struct {
        int          id;
        logic [7:0]  r1;
        logic [7:0]  r2;
        logic [15:0] pc;
    } exp_t;

    vec_t vecs[17];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] wi, input logic [7:0] wd,
                                input logic fe, input logic [7:0] fd,
                                input logic [1:0] op, input logic [2:0] pair, input logic pl,
                                input logic [3:0] r1, input logic [3:0] r2,
                                input logic [15:0] ei, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [15:0] ep);
        vec_t v;
        v.we = we; v.wi = wi; v.wd = wd; v.fe = fe; v.fd = fd;
        v.op = op; v.pair = pair; v.pl = pl; v.r1 = r1; v.r2 = r2;
        v.exp_inc = ei; v.exp_r1 = e1; v.exp_r2 = e2; v.exp_pc = ep;
        return v;
    endfunction

    task automatic idle_inputs();
        wr_en = 1'b0; wr_idx = 4'd0; wr_data = 8'h00;
        flag_wr_en = 1'b0; flag_data = 8'h00;
        inc_op = 2'd0; inc_pair = 3'd0; pc_load = 1'b0;
    endtask

    // Entered at a negedge with t_cycle = 0; leaves at the next t_cycle = 0.
    task automatic apply_vec(input int id, input vec_t v);
        logic got;
        exp_t e;
        wr_en = v.we; wr_idx = v.wi; wr_data = v.wd;
        flag_wr_en = v.fe; flag_data = v.fd;
        inc_op = v.op; inc_pair = v.pair; pc_load = v.pl;
        rd1_idx = v.r1; rd2_idx = v.r2;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (commit === 1'b1) got = 1'b1;
            else begin @(posedge clk); @(negedge clk); end
        end
        chk($sformatf("v%0d_commit_seen", id), 32'(got), 32'd1);
        chk($sformatf("v%0d_inc_out", id), 32'(inc_out), 32'(v.exp_inc));
        e.id = id; e.r1 = v.exp_r1; e.r2 = v.exp_r2; e.pc = v.exp_pc;
        exp_q.push_back(e);
        @(posedge clk); @(negedge clk);
        idle_inputs();
        e = exp_q.pop_front();
        chk($sformatf("v%0d_tcycle0", e.id), 32'(t_cycle), 32'd0);
        chk($sformatf("v%0d_rd1", e.id), 32'(rd1_data), 32'(e.r1));
        chk($sformatf("v%0d_rd2", e.id), 32'(rd2_data), 32'(e.r2));
        chk($sformatf("v%0d_pc", e.id), 32'(pc), 32'(e.pc));
    endtask

    initial begin
        int clocks, commits, stalls;
        logic [15:0] m0;

        //           we  wi     wd     fe  fd     op   pair pl  r1  r2  inc_out  rd1    rd2    pc
        vecs[0]  = mk(1, 4'd4,  8'hFF, 0, 8'h00, 2'd0, 3'd0, 0, 4, 5,  16'h0000, 8'hFF, 8'h00, 16'h0100);
        vecs[1]  = mk(1, 4'd5,  8'hFF, 0, 8'h00, 2'd0, 3'd2, 0, 4, 5,  16'hFF00, 8'hFF, 8'hFF, 16'h0100);
        vecs[2]  = mk(0, 4'd0,  8'h00, 0, 8'h00, 2'd3, 3'd2, 0, 4, 5,  16'h0000, 8'hFF, 8'hFF, 16'h0100);
        vecs[3]  = mk(0, 4'd0,  8'h00, 0, 8'h00, 2'd1, 3'd2, 0, 4, 5,  16'h0000, 8'h00, 8'h00, 16'h0100);
        vecs[4]  = mk(1, 4'd4,  8'h12, 0, 8'h00, 2'd1, 3'd2, 0, 4, 5,  16'h0001, 8'h00, 8'h01, 16'h0100);
        vecs[5]  = mk(0, 4'd0,  8'h00, 0, 8'h00, 2'd2, 3'd2, 0, 4, 5,  16'h0000, 8'h00, 8'h00, 16'h0100);
        vecs[6]  = mk(0, 4'd0,  8'h00, 0, 8'h00, 2'd2, 3'd2, 0, 4, 5,  16'hFFFF, 8'hFF, 8'hFF, 16'h0100);
        vecs[7]  = mk(0, 4'd0,  8'h00, 1, 8'hFF, 2'd0, 3'd0, 0, 6, 7,  16'h0000, 8'hF0, 8'h00, 16'h0100);
        vecs[8]  = mk(1, 4'd6,  8'h5A, 0, 8'h00, 2'd0, 3'd0, 0, 6, 7,  16'h0000, 8'h50, 8'h00, 16'h0100);
        vecs[9]  = mk(1, 4'd6,  8'hC5, 1, 8'h30, 2'd0, 3'd0, 0, 6, 7,  16'h0000, 8'hC0, 8'h00, 16'h0100);
        vecs[10] = mk(1, 4'd7,  8'hFF, 0, 8'h00, 2'd0, 3'd3, 0, 6, 7,  16'hC000, 8'hC0, 8'hFF, 16'h0100);
        vecs[11] = mk(0, 4'd0,  8'h00, 0, 8'h00, 2'd1, 3'd3, 0, 6, 7,  16'hC100, 8'hC0, 8'h00, 16'h0100);
        vecs[12] = mk(0, 4'd0,  8'h00, 0, 8'h00, 2'd1, 3'd6, 1, 12, 13, 16'h0101, 8'h01, 8'h01, 16'h0101);
        vecs[13] = mk(1, 4'd12, 8'h55, 0, 8'h00, 2'd0, 3'd2, 1, 12, 13, 16'hFFFF, 8'hFF, 8'hFF, 16'hFFFF);
        vecs[14] = mk(0, 4'd0,  8'h00, 0, 8'h00, 2'd1, 3'd6, 0, 12, 13, 16'h0000, 8'h00, 8'h00, 16'h0000);
        vecs[15] = mk(1, 4'd14, 8'hAA, 0, 8'h00, 2'd1, 3'd7, 0, 14, 15, 16'h0001, 8'h00, 8'h00, 16'h0000);
        vecs[16] = mk(0, 4'd0,  8'h00, 0, 8'h00, 2'd2, 3'd6, 1, 0, 1,  16'hFFFF, 8'h00, 8'h00, 16'hFFFF);

        reset = 1'b1; mem_ready = 1'b1;
        rd1_idx = 4'd0; rd2_idx = 4'd0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_tcycle", 32'(t_cycle), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_mcycle", 32'(mcycle_count), 32'd0);
        chk("rst_pc", 32'(pc), 32'h0100);
        for (int i = 0; i < 12; i++) begin
            rd1_idx = 4'(i);
            #1;
            chk($sformatf("rst_reg%0d", i), 32'(rd1_data), 32'd0);
        end
        reset = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("idle_mcycle", 32'(mcycle_count), 32'd2);
        chk("idle_tcycle", 32'(t_cycle), 32'd0);

        for (int i = 0; i < 17; i++) apply_vec(i, vecs[i]);
        chk("vec_mcycle", 32'(mcycle_count), 32'd19);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset at t_cycle 2 with pc_load pending (inc_out = pair 0 = 0x0000)
        pc_load = 1'b1; inc_op = 2'd0; inc_pair = 3'd0; rd1_idx = 4'd4;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("rst2_at_t2", 32'(t_cycle), 32'd2);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst2_tcycle", 32'(t_cycle), 32'd0);
        chk("rst2_pc", 32'(pc), 32'h0100);
        chk("rst2_mcycle", 32'(mcycle_count), 32'd0);
        chk("rst2_reg4", 32'(rd1_data), 32'd0);

        // Reset on the final T-cycle must suppress commit
        reset = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("rst3_at_t3", 32'(t_cycle), 32'd3);
        chk("rst3_commit_before", 32'(commit), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst3_commit_gated", 32'(commit), 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        chk("rst3_pc", 32'(pc), 32'h0100);
        chk("rst3_mcycle", 32'(mcycle_count), 32'd0);

        // Memory wait-state sequence, with a byte write to reg 0
        m0 = mcycle_count;
        wr_en = 1'b1; wr_idx = 4'd0; wr_data = 8'h77; rd1_idx = 4'd0;
        clocks = 0; commits = 0; stalls = 0;
        for (int k = 0; k < 20; k++) begin
            if (t_cycle == 2'd3 && stalls < 3) begin
                mem_ready = 1'b0; stalls++;
            end else if (t_cycle == 2'd3) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (commit === 1'b1) commits++;
            @(posedge clk); @(negedge clk);
            clocks++;
            if (t_cycle == 2'd0) break;
        end
        mem_ready = 1'b1;
        idle_inputs();
`ifdef CPU_REGFILE_STALL_EN
        chk("stall_clocks", 32'(clocks), 32'd7);
`else
        chk("stall_clocks", 32'(clocks), 32'd4);
`endif
        chk("stall_commits", 32'(commits), 32'd1);
        chk("stall_mcycle", 32'(mcycle_count), 32'(m0 + 16'd1));
        chk("stall_reg0", 32'(rd1_data), 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
